rotator_sequencer: RTL and testbench
====================================

// Module: rotator_sequencer
// PURPOSE
//  Controls the time-multiplexed complex rotator of one radix-2 SDF FFT stage.
//  Input is an interleaved stream: real word, then imag word, per complex sample.
//  Tracks word phase and sample index within the frame, and drives rotator sw.
//  Issues twiddle-ROM address/enable one cycle ahead and flags rotator output words valid.
// PARAMETERS
//  N_FFT    16               FFT points per frame (power of 2, >=4)
//  STAGE    0                stage index s, 0..log2(N_FFT)-1; block length L = N_FFT>>s
//  ADDR_W   $clog2(N_FFT)-1  twiddle ROM address width (ROM holds N_FFT/2 entries)
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       async active-low reset
//  in_valid     in   1       din word of rotator is valid this cycle
//  in_first     in   1       with in_valid: this word is real word of sample 0 of a frame
//  sw           out  1       rotator sw; 1 while the imag word is on din
//  tw_en        out  1       twiddle ROM register enable
//  tw_addr      out  ADDR_W  twiddle ROM address, sampled when tw_en=1
//  out_valid    out  1       rotator dout is a valid result word this cycle
//  out_is_im    out  1       with out_valid: 0 = real result, 1 = imag result
//  frame_done   out  1       1-cycle pulse: imag word of sample N_FFT-1 accepted
//  err_proto    out  1       sticky: in_valid dropped between real and imag words
//  err_sync     out  1       sticky: in_first seen when sample index != 0 or phase != 0
// BEHAVIOUR
//  Reset (async, rst_n=0): phase=0, n=0, im_pend=0, frame_done=0, err_*=0.
//   sw, tw_en and out_valid are then 0. Release is synchronous to clk.
//  State: phase (1b, 0=real word expected), n (sample index 0..N_FFT-1), im_pend.
//  Word accept: in_valid=1. Phase 0 -> 1 on accept. Phase 1 -> 0 on accept, and n increments.
//   n wraps N_FFT-1 -> 0.
//  Phase 0 accept: tw_en=1 (comb: in_valid & ~phase), tw_addr = twiddle index of sample n.
//   The ROM registers the twiddle on the next edge. It then holds it for the imag cycle and the following cycle.
//  Twiddle index: j = n mod L. If j < L/2: addr=0 (W^0, identity).
//   Else addr = (j - L/2) << STAGE, computed as an unsigned ADDR_W-bit value.
//  sw = phase (registered). It is independent of in_valid so the rotator mux sees a stable select.
//  Output timing: the real result is combinational in the imag-word cycle. The imag result comes the next cycle.
//   out_valid = (in_valid & phase) | im_pend. out_is_im = im_pend.
//   im_pend <= in_valid & phase. It is set for exactly one cycle, independent of next input.
//  Gaps (in_valid=0) are allowed only with phase=0; state holds.
//  Gap at phase=1: set err_proto, force phase=0 and keep n. No out_valid for that sample.
//   The following word is treated as a real word.
//  in_first with in_valid: forces n=0 and treats the word as real (phase 0 behaviour).
//   If n!=0 or phase!=0 beforehand, set err_sync (resync; partial frame abandoned).
//   in_first at phase 1 overrides the imag interpretation. No out_valid real result that cycle.
//  in_first with in_valid=0 is ignored.
//  frame_done: registered pulse, one cycle after the phase-1 accept with n=N_FFT-1.
//  Back-to-back frames: n wraps to 0 with no idle cycle required; in_first on the wrap is legal (no err).
//  err_proto and err_sync clear only on reset.
// TESTING
//  1 N=16,S=0, 32 contiguous words with in_first on word 0
//    -> tw_addr on real words: n=0..7 ->0; n=8..15 ->0..7.
//    -> sw toggles 0,1,...; frame_done 1 cycle after word 31.
//  2 N=16,S=1, one frame -> addr per sample: 0,0,0,0,0,2,4,6 repeated twice.
//    N=16,S=3 -> all addr 0.
//  3 Idle gaps of 0..3 cycles between samples -> identical addr/out_valid sequence to test 1, no errors.
//    im_pend still fires in the gap cycle.
//  4 in_valid low after a real word at n=5 -> err_proto=1, phase=0, n stays 5, no out_valid for it.
//    Next two words give valid real/imag at n=5.
//  5 in_first at n=9 -> err_sync=1, n=0, addr 0.
//    Full frame follows correctly; a second in_first exactly at wrap -> no error.
//  6 rst_n low mid-frame (phase=1, n=11), asynchronously -> all outputs 0 immediately.
//    After release, the first real word is n=0.
//  Bench: rotator + ROM model; compare dout to reference complex multiply, tolerance 1 LSB.

Source files
------------

// File: rtl/rotator_sequencer.sv
// Sequencer for the time-multiplexed complex rotator of one radix-2 SDF FFT stage.
// The input stream interleaves a real word and an imag word per complex sample.
// This block tracks the word phase and the sample index within the frame.
// It also drives the rotator sw select.
// It issues the twiddle-ROM address/enable one cycle ahead of use.
// It flags which rotator output words are valid results.
module rotator_sequencer #(
  parameter int N_FFT  = 16,
  parameter int STAGE  = 0,
  parameter int ADDR_W = $clog2(N_FFT) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_first,
  output logic              sw,
  output logic              tw_en,
  output logic [ADDR_W-1:0] tw_addr,
  output logic              out_valid,
  output logic              out_is_im,
  output logic              frame_done,
  output logic              err_proto,
  output logic              err_sync
);

  localparam int N_W   = $clog2(N_FFT);
  localparam int BLK_L = N_FFT >> STAGE;

  // Masks and limits for the sample-index arithmetic.
  localparam logic [N_W-1:0] L_MASK = N_W'(BLK_L - 1);
  localparam logic [N_W-1:0] HALF_L = N_W'(BLK_L / 2);
  localparam logic [N_W-1:0] N_LAST = N_W'(N_FFT - 1);

  logic           phase;    // 0: real word expected, 1: imag word expected
  logic [N_W-1:0] n;        // sample index within the frame
  logic           im_pend;  // imag result appears on dout this cycle

  logic           accept_first;
  logic           accept_re;
  logic           accept_im;
  logic [N_W-1:0] n_eff;
  logic [N_W-1:0] j;
  logic [N_W-1:0] rel;
  logic [N_W-1:0] rot;

  // An in_first word always restarts at sample 0 as a real word.
  // This holds even if an imag word was expected.
  assign accept_first = in_valid & in_first;
  assign accept_re    = in_valid & (~phase | in_first);
  assign accept_im    = in_valid & phase & ~in_first;

  assign sw        = phase;
  assign tw_en     = accept_re;
  assign out_valid = accept_im | im_pend;
  assign out_is_im = im_pend;

  // Twiddle index for the sample being started.
  // The first half of each block uses W^0; the second half steps by 2^STAGE.
  // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
  always_comb begin
    n_eff   = accept_first ? '0 : n;
    j       = n_eff & L_MASK;
    rel     = j - HALF_L;
    rot     = rel << STAGE;
    tw_addr = '0;
    if (j >= HALF_L) begin
      tw_addr = rot[ADDR_W-1:0];
    end
  end

  // Word phase, sample index, result-valid pipeline and sticky error flags.
  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase      <= 1'b0;
      n          <= '0;
      im_pend    <= 1'b0;
      frame_done <= 1'b0;
      err_proto  <= 1'b0;
      err_sync   <= 1'b0;
    end else begin
      im_pend    <= accept_im;
      frame_done <= accept_im && (n == N_LAST);
      if (accept_first) begin
        if ((n != '0) || phase) begin
          err_sync <= 1'b1;
        end
        n     <= '0;
        phase <= 1'b1;
      end else if (in_valid) begin
        if (phase) begin
          phase <= 1'b0;
          n     <= n + 1'b1;
        end else begin
          phase <= 1'b1;
        end
      end else if (phase) begin
        // The imag word went missing; drop the sample and expect a real word next.
        err_proto <= 1'b1;
        phase     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rotator_sequencer.sv
// Self-checking bench for rotator_sequencer.
// Three instances (STAGE 0, 1, 3) share one input stream.
// A word-level reference model and a twiddle-ROM register model check the outputs.
module tb_rotator_sequencer;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_first = 1'b0;

  logic       sw0, tw_en0, ov0, oi0, fd0, errp0, errs0;
  logic [2:0] addr0;
  logic       sw1, tw_en1, ov1, oi1, fd1, errp1, errs1;
  logic [2:0] addr1;
  logic       sw3, tw_en3, ov3, oi3, fd3, errp3, errs3;
  logic [2:0] addr3;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept in plain word/sample terms.
  int m_n, m_phase, m_pend, m_fd, m_errp, m_errs, m_last_n;

  // Twiddle ROM output register driven by the STAGE-0 instance.
  logic [2:0] rom_q;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (tw_en0) rom_q <= addr0;
  end

  rotator_sequencer #(.N_FFT(N), .STAGE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .sw(sw0), .tw_en(tw_en0), .tw_addr(addr0), .out_valid(ov0), .out_is_im(oi0),
    .frame_done(fd0), .err_proto(errp0), .err_sync(errs0));

  rotator_sequencer #(.N_FFT(N), .STAGE(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .sw(sw1), .tw_en(tw_en1), .tw_addr(addr1), .out_valid(ov1), .out_is_im(oi1),
    .frame_done(fd1), .err_proto(errp1), .err_sync(errs1));

  rotator_sequencer #(.N_FFT(N), .STAGE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .sw(sw3), .tw_en(tw_en3), .tw_addr(addr3), .out_valid(ov3), .out_is_im(oi3),
    .frame_done(fd3), .err_proto(errp3), .err_sync(errs3));

  // Twiddle index from the stage rule.
  // Block length L = N >> s and j = n mod L.
  // The first half of each block uses W^0; the second half uses (j - L/2) * 2^s.
  function automatic int addr_of(input int n, input int s);
    int l, j;
    l = N >> s;
    j = n % l;
    if (j < l / 2) return 0;
    return ((j - l / 2) << s) % (N / 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_phase = 0; m_pend = 0; m_fd = 0; m_errp = 0; m_errs = 0; m_last_n = 0;
  endtask

  // One clock cycle.
  // The task is entered at posedge+1 and drives the inputs.
  // It checks the outputs at the negedge, then advances the model.
  task automatic step(input bit v, input bit f);
    bit real_w, imag_w;
    int ne;
    in_valid = v;
    in_first = f;
    @(negedge clk);
    real_w = v && (f || m_phase == 0);
    imag_w = v && (m_phase == 1) && !f;
    ne = f ? 0 : m_n;
    check("sw", sw0, m_phase);
    check("tw_en", tw_en0, real_w);
    if (real_w) begin
      check("tw_addr_s0", addr0, addr_of(ne, 0));
      check("tw_addr_s1", addr1, addr_of(ne, 1));
      check("tw_addr_s3", addr3, addr_of(ne, 3));
    end
    check("out_valid", ov0, imag_w || m_pend);
    check("out_is_im", oi0, m_pend);
    if (imag_w || m_pend) check("rom_hold", rom_q, addr_of(m_last_n, 0));
    check("frame_done", fd0, m_fd);
    check("err_proto", errp0, m_errp);
    check("err_sync", errs0, m_errs);
    if (real_w) m_last_n = ne;
    m_pend = imag_w;
    m_fd   = imag_w && (m_n == N - 1);
    if (v && f) begin
      if (m_n != 0 || m_phase != 0) m_errs = 1;
      m_n = 0;
      m_phase = 1;
    end else if (v) begin
      if (m_phase == 0) m_phase = 1;
      else begin
        m_phase = 0;
        m_n = (m_n + 1) % N;
      end
    end else if (m_phase == 1) begin
      m_errp = 1;
      m_phase = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input bit first, input int gap);
    repeat (gap) step(1'b0, 1'b0);
    step(1'b1, first);
    step(1'b1, 1'b0);
  endtask

  // Reset asserted away from any clock edge.
  // All outputs must read 0 right away.
  task automatic async_reset();
    in_valid = 1'b0;
    in_first = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_sw", sw0, 0);
    check("rst_tw_en", tw_en0, 0);
    check("rst_out_valid", ov0, 0);
    check("rst_out_is_im", oi0, 0);
    check("rst_frame_done", fd0, 0);
    check("rst_err_proto", errp0, 0);
    check("rst_err_sync", errs0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    check("init_sw", sw0, 0);
    check("init_tw_en", tw_en0, 0);
    check("init_out_valid", ov0, 0);
    check("init_frame_done", fd0, 0);
    check("init_err_sync", errs0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two back-to-back frames; in_first on the wrap is legal.
    for (int w = 0; w < 64; w++) step(1'b1, (w == 0) || (w == 32));
    check("wrap_no_sync_err", errs0, 0);

    // One frame with random idle gaps between samples.
    for (int s = 0; s < N; s++) sample(s == 0, $urandom_range(0, 3));
    check("gaps_no_proto_err", errp0, 0);

    // Imag word missing at n=5; the retry re-issues sample 5.
    for (int s = 0; s < 5; s++) sample(s == 0, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("proto_err_set", errp0, 1);
    sample(1'b0, 0);
    sample(1'b0, 1);

    // in_first at n=9 resyncs to sample 0.
    for (int s = 7; s < 9; s++) sample(1'b0, 0);
    step(1'b1, 1'b1);
    check("sync_err_set", errs0, 1);
    step(1'b1, 1'b0);
    for (int s = 1; s < N; s++) sample(1'b0, 0);
    // in_first in place of an imag word.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);

    // Random stress from a clean reset state.
    async_reset();
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0);
    end

    // Reset mid-frame at phase 1, n=11.
    async_reset();
    for (int s = 0; s < 11; s++) sample(s == 0, 0);
    step(1'b1, 1'b0);
    check("pre_rst_phase", sw0, 1);
    async_reset();
    for (int s = 0; s < 12; s++) sample(1'b0, 0);
    step(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
